// File: rtl/fft4.sv
// 4-point radix-2 DIT FFT on four 1-bit real samples; two register stages (butterflies, then outputs).
// Latency 2 clocks, one sample set per clock; no backpressure, data registers load every cycle.
module fft4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] inp,
  output logic       out_valid,
  output logic [2:0] rout_0,
  output logic [2:0] rout_1,
  output logic [2:0] rout_2,
  output logic [2:0] rout_3,
  output logic [2:0] iout_0,
  output logic [2:0] iout_1,
  output logic [2:0] iout_2,
  output logic [2:0] iout_3
);

  // a0/b0 are unsigned sums (0..2); a1/b1 are two's complement differences (-1..1)
  typedef struct packed {
    logic [1:0] a0;
    logic [1:0] a1;
    logic [1:0] b0;
    logic [1:0] b1;
  } bfly_t;

  bfly_t bfly_nxt;
  bfly_t bfly_q;
  logic  vld_q;

  logic [2:0] a0_ext;
  logic [2:0] a1_ext;
  logic [2:0] b0_ext;
  logic [2:0] b1_ext;

  always_comb begin
    bfly_nxt.a0 = {1'b0, inp[0]} + {1'b0, inp[2]};
    bfly_nxt.a1 = {1'b0, inp[0]} - {1'b0, inp[2]};
    bfly_nxt.b0 = {1'b0, inp[1]} + {1'b0, inp[3]};
    bfly_nxt.b1 = {1'b0, inp[1]} - {1'b0, inp[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bfly_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      bfly_q <= bfly_nxt;
      vld_q  <= in_valid;
    end
  end

  assign a0_ext = {1'b0, bfly_q.a0};
  assign b0_ext = {1'b0, bfly_q.b0};
  assign a1_ext = {bfly_q.a1[1], bfly_q.a1};
  assign b1_ext = {bfly_q.b1[1], bfly_q.b1};

  // X[3] is conj(X[1]) for real input, so both bins share a1 and differ only in the sign of b1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rout_0    <= '0;
      rout_1    <= '0;
      rout_2    <= '0;
      rout_3    <= '0;
      iout_1    <= '0;
      iout_3    <= '0;
    end else begin
      out_valid <= vld_q;
      rout_0    <= a0_ext + b0_ext;
      rout_2    <= a0_ext - b0_ext;
      rout_1    <= a1_ext;
      rout_3    <= a1_ext;
      iout_1    <= 3'd0 - b1_ext;
      iout_3    <= b1_ext;
    end
  end

  assign iout_0 = 3'd0;
  assign iout_2 = 3'd0;

endmodule

// File: tb/tb_fft4.sv
// Directed bench for fft4: literal vectors, a DFT reference model checked every cycle, and async reset.
module tb_fft4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] inp = 4'hF;
  logic       out_valid;
  logic [2:0] rout_0, rout_1, rout_2, rout_3;
  logic [2:0] iout_0, iout_1, iout_2, iout_3;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;
  logic [4:0] hist_q[$];

  fft4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .inp      (inp),
    .out_valid(out_valid),
    .rout_0   (rout_0),
    .rout_1   (rout_1),
    .rout_2   (rout_2),
    .rout_3   (rout_3),
    .iout_0   (iout_0),
    .iout_1   (iout_1),
    .iout_2   (iout_2),
    .iout_3   (iout_3)
  );

  always #5 clk = ~clk;

  // Direct DFT: W4^m for m = 0..3 is 1, -j, -1, +j.  Packed {r0,r1,r2,r3,i0,i1,i2,i3}.
  function automatic logic [23:0] dft(input logic [3:0] x);
    int re [4];
    int im [4];
    logic [23:0] r;
    for (int k = 0; k < 4; k++) begin
      re[k] = 0;
      im[k] = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: re[k] += int'(x[n]);
          1: im[k] -= int'(x[n]);
          2: re[k] -= int'(x[n]);
          default: im[k] += int'(x[n]);
        endcase
      end
    end
    r = {3'(re[0]), 3'(re[1]), 3'(re[2]), 3'(re[3]),
         3'(im[0]), 3'(im[1]), 3'(im[2]), 3'(im[3])};
    return r;
  endfunction

  function automatic logic [23:0] dut_word();
    return {rout_0, rout_1, rout_2, rout_3, iout_0, iout_1, iout_2, iout_3};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference history: samples captured at each live edge; reset flushes anything in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q.delete();
    end else begin
      hist_q.push_back({in_valid, inp});
      if (hist_q.size() > 2) void'(hist_q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [23:0] exp_w;
    logic        exp_v;
    if (chk_en) begin
      if (hist_q.size() >= 2) begin
        exp_w = dft(hist_q[0][3:0]);
        exp_v = hist_q[0][4];
      end else begin
        exp_w = '0;
        exp_v = 1'b0;
      end
      check("model_bins", {8'd0, dut_word()}, {8'd0, exp_w});
      check("model_valid", {31'd0, out_valid}, {31'd0, exp_v});
      check("sym_re", {29'd0, rout_3}, {29'd0, rout_1});
      check("sym_im", {29'd0, iout_3}, {29'd0, 3'(3'd0 - iout_1)});
    end
  end

  task automatic drive(input logic [3:0] v, input logic vld);
    @(posedge clk);
    #1;
    inp      = v;
    in_valid = vld;
  endtask

  task automatic directed(input string name, input logic [3:0] v, input logic [23:0] want);
    check({name, "_model"}, {8'd0, dft(v)}, {8'd0, want});
    drive(v, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check(name, {8'd0, dut_word()}, {8'd0, want});
    check({name, "_vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_bins", {8'd0, dut_word()}, 32'd0);
    check("reset_vld", {31'd0, out_valid}, 32'd0);
    chk_en = 1'b1;
    #10 rst_n = 1'b1;

    directed("x0", 4'b0001, {3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0});
    directed("all1", 4'b1111, {3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0});
    directed("x1", 4'b0010, {3'd1, 3'd0, 3'b111, 3'd0, 3'd0, 3'b111, 3'd0, 3'd1});
    directed("x1x3", 4'b1010, {3'd2, 3'd0, 3'b110, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0});

    for (int v = 0; v < 16; v++) begin
      drive(4'(v), (v != 5) && (v != 12));
      if (v == 9) begin
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bins", {8'd0, dut_word()}, 32'd0);
        check("midrst_vld", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end
    drive(4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #6;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
